// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared sizing, empty-output constant and entry layout for the fetch queue.
package ifetch_queue_pkg;
  localparam int IFQ_DEPTH = 4;
  localparam int IFQ_AW = 2;
  localparam logic [31:0] NOP_INS = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ifq_entry_t;
endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: fetch-side push, issue-side pop, flush and occupancy of the fetch queue.
interface ifetch_queue_if
  import ifetch_queue_pkg::*;
#(
  parameter int AW = IFQ_AW
);
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_ins;
  logic          fetch_ready;
  logic          issue_valid;
  logic [31:0]   issue_pc;
  logic [31:0]   issue_ins;
  logic          issue_ready;
  logic          flush;
  logic [AW:0]   count;
  modport master (
    output fetch_valid, fetch_pc, fetch_ins, issue_ready, flush,
    input  fetch_ready, issue_valid, issue_pc, issue_ins, count
  );
  modport slave (
    input  fetch_valid, fetch_pc, fetch_ins, issue_ready, flush,
    output fetch_ready, issue_valid, issue_pc, issue_ins, count
  );
endinterface

// File: rtl/ifetch_queue_storage.sv
// ifetch_queue_storage: DEPTH x {pc, ins} register array, one sync write port, one comb read port, async clear.
module ifetch_queue_storage
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  ifq_entry_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output ifq_entry_t    o_rdata
);
  ifq_entry_t r_mem [DEPTH];
  always_ff @(posedge clk or negedge nRST)
    if (!nRST)
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (i_we)
      r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: FIFO of fetched {pc, ins} between the PC stage and issue, with back-pressure and flush.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW
) (
  input  logic          clk,
  input  logic          nRST,
  ifetch_queue_if.slave bus
);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0] r_head, r_tail;
  logic        w_empty, w_full, w_push, w_pop;
  ifq_entry_t  w_rdata;
  assign w_empty = r_head == r_tail;
  assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
  assign bus.fetch_ready = !w_full && !bus.flush;
  assign bus.issue_valid = !w_empty && !bus.flush;
  assign bus.issue_pc    = w_empty ? NOP_INS : w_rdata.pc;
  assign bus.issue_ins   = w_empty ? NOP_INS : w_rdata.ins;
  assign bus.count       = r_tail - r_head;
  assign w_push = bus.fetch_valid && bus.fetch_ready;
  assign w_pop  = bus.issue_valid && bus.issue_ready;
  // flush wins: fetch_ready/issue_valid are already low, so push/pop cannot fire with it
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + ONE;
      if (w_pop) r_head <= r_head + ONE;
    end
  ifetch_queue_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
    .clk     (clk),
    .nRST    (nRST),
    .i_we    (w_push),
    .i_waddr (r_tail[AW-1:0]),
    .i_wdata ('{pc: bus.fetch_pc, ins: bus.fetch_ins}),
    .i_raddr (r_head[AW-1:0]),
    .o_rdata (w_rdata)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue (DEPTH 4).
module tb_ifetch_queue;
  logic clk;
  logic nRST;
  int   n_vec;
  int   n_err;
  ifetch_queue_if #(.AW(2)) bus ();
  ifetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    nRST = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_pc = '0;
    bus.fetch_ins = '0;
    bus.issue_ready = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_issue_pc", bus.issue_pc, 32'h0);
    chk("rst_issue_ins", bus.issue_ins, 32'h0);
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    #11;
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc = 32'(4 * i);
      bus.fetch_ins = 32'hA0 + 32'(i);
      tick();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
    end
    chk("full_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    chk("full_issue_valid", 32'(bus.issue_valid), 32'd1);
    bus.fetch_pc = 32'd16;
    bus.fetch_ins = 32'hA4;
    tick();
    chk("ignored_push_count", 32'(bus.count), 32'd4);
    bus.fetch_valid = 1'b0;
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", bus.issue_pc, 32'(4 * i));
      chk("drain_ins", bus.issue_ins, 32'hA0 + 32'(i));
      chk("drain_valid", 32'(bus.issue_valid), 32'd1);
      tick();
    end
    chk("drained_valid", 32'(bus.issue_valid), 32'd0);
    chk("drained_pc", bus.issue_pc, 32'h0);
    chk("drained_ins", bus.issue_ins, 32'h0);
    chk("drained_count", 32'(bus.count), 32'd0);
    bus.issue_ready = 1'b0;
    bus.fetch_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.fetch_pc = 32'h200 + 32'(4 * i);
      bus.fetch_ins = 32'hB00 + 32'(i);
      tick();
    end
    chk("pp_start_count", 32'(bus.count), 32'd2);
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.fetch_pc = 32'h208 + 32'(4 * k);
      bus.fetch_ins = 32'hB02 + 32'(k);
      chk("pp_head_pc", bus.issue_pc, 32'h200 + 32'(4 * k));
      chk("pp_head_ins", bus.issue_ins, 32'hB00 + 32'(k));
      chk("pp_fetch_ready", 32'(bus.fetch_ready), 32'd1);
      tick();
      chk("pp_count", 32'(bus.count), 32'd2);
    end
    bus.issue_ready = 1'b0;
    bus.fetch_pc = 32'h230;
    bus.fetch_ins = 32'hB0C;
    tick();
    chk("pre_flush_count", 32'(bus.count), 32'd3);
    chk("pre_flush_pc", bus.issue_pc, 32'h228);
    bus.flush = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h300;
    bus.issue_ready = 1'b1;
    #1;
    chk("flush_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    chk("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
    tick();
    bus.flush = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.issue_ready = 1'b0;
    #1;
    chk("post_flush_count", 32'(bus.count), 32'd0);
    chk("post_flush_valid", 32'(bus.issue_valid), 32'd0);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h40;
    bus.fetch_ins = 32'hC0;
    tick();
    chk("after_flush_pc", bus.issue_pc, 32'h40);
    chk("after_flush_count", 32'(bus.count), 32'd1);
    for (int i = 1; i < 3; i++) begin
      bus.fetch_pc = 32'h40 + 32'(4 * i);
      bus.fetch_ins = 32'hC0 + 32'(i);
      tick();
    end
    bus.fetch_valid = 1'b0;
    chk("pre_areset_count", 32'(bus.count), 32'd3);
    #2;
    nRST = 1'b0;
    #1;
    chk("areset_count", 32'(bus.count), 32'd0);
    chk("areset_valid", 32'(bus.issue_valid), 32'd0);
    chk("areset_pc", bus.issue_pc, 32'h0);
    chk("areset_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    #2;
    nRST = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h80;
    bus.fetch_ins = 32'hD0;
    tick();
    bus.fetch_valid = 1'b0;
    chk("post_areset_count", 32'(bus.count), 32'd1);
    chk("post_areset_pc", bus.issue_pc, 32'h80);
    chk("post_areset_ins", bus.issue_ins, 32'hD0);
    bus.issue_ready = 1'b1;
    tick();
    chk("lat_empty_count", 32'(bus.count), 32'd0);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = 32'h100;
    bus.fetch_ins = 32'h1234;
    #1;
    chk("lat_push_cycle_valid", 32'(bus.issue_valid), 32'd0);
    tick();
    bus.fetch_valid = 1'b0;
    chk("lat_next_valid", 32'(bus.issue_valid), 32'd1);
    chk("lat_next_pc", bus.issue_pc, 32'h100);
    chk("lat_next_count", 32'(bus.count), 32'd1);
    tick();
    chk("lat_popped_valid", 32'(bus.issue_valid), 32'd0);
    chk("lat_popped_count", 32'(bus.count), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
